// File: rtl/jk_reg_bank.sv
// jk_reg_bank: a WIDTH-bit bank of JK cells sharing one clock and reset.
// The same JK cell update is reused for every mode; counting and loading
// are produced by generating per-bit J/K values in front of the cells.
module jk_reg_bank #(
    parameter int               WIDTH     = 4,
    parameter int               MAX_COUNT = 2**WIDTH - 1,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             TC
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] up_toggle;
    logic [WIDTH-1:0] down_toggle;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;
    logic             at_max;
    logic             above_max;
    logic             at_zero;

    assign mode_s    = mode_e'(MODE);
    assign at_max    = (q_q == MAX_VAL);
    assign above_max = (q_q >= MAX_VAL);
    assign at_zero   = (q_q == '0);

    // Ripple carry/borrow chains: a bit toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin : toggle_chain
        logic carry;
        logic borrow;
        carry       = 1'b1;
        borrow      = 1'b1;
        up_toggle   = '0;
        down_toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_toggle[i]   = carry;
            down_toggle[i] = borrow;
            carry          = carry & q_q[i];
            borrow         = borrow & ~q_q[i];
        end
    end

    // Per-bit J/K generation; the wrap cases force the cells to clear or to load MAX_COUNT.
    always_comb begin
        j_eff = '0;
        k_eff = '0;
        if (EN) begin
            case (mode_s)
                MODE_JK: begin
                    j_eff = J;
                    k_eff = K;
                end
                MODE_UP: begin
                    if (above_max) begin
                        j_eff = '0;
                        k_eff = '1;
                    end else begin
                        j_eff = up_toggle;
                        k_eff = up_toggle;
                    end
                end
                MODE_DOWN: begin
                    if (at_zero) begin
                        j_eff = MAX_VAL;
                        k_eff = ~MAX_VAL;
                    end else begin
                        j_eff = down_toggle;
                        k_eff = down_toggle;
                    end
                end
                MODE_LOAD: begin
                    j_eff = D;
                    k_eff = ~D;
                end
            endcase
        end
    end

    // JK cell behaviour for every bit: hold, clear, set or toggle.
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({j_eff[i], k_eff[i]})
                2'b01:   q_d[i] = 1'b0;
                2'b10:   q_d[i] = 1'b1;
                2'b11:   q_d[i] = ~q_q[i];
                default: q_d[i] = q_q[i];
            endcase
        end
    end

    // State register with asynchronous reset to RST_VAL.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // Terminal count flags the cycle before a wrap so a following stage can use it as enable.
    always_comb begin
        TC = 1'b0;
        if (EN) begin
            if (mode_s == MODE_UP && at_max) begin
                TC = 1'b1;
            end else if (mode_s == MODE_DOWN && at_zero) begin
                TC = 1'b1;
            end
        end
    end

    assign Q    = q_q;
    assign Qbar = ~q_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Testbench for jk_reg_bank: directed scenarios plus randomized traffic,
// all compared against an arithmetic reference model of the bank.
module tb_jk_reg_bank;

    localparam int         W    = 4;
    localparam int         MAXC = 9;
    localparam logic [3:0] RSTV = 4'b0011;

    logic         CLK;
    logic         RST;
    logic         EN;
    logic [1:0]   MODE;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] Qbar;
    logic         TC;

    logic [W-1:0] exp_q;
    int           checks;
    int           errors;

    jk_reg_bank #(
        .WIDTH    (W),
        .MAX_COUNT(MAXC),
        .RST_VAL  (RSTV)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .MODE(MODE),
        .J   (J),
        .K   (K),
        .D   (D),
        .Q   (Q),
        .Qbar(Qbar),
        .TC  (TC)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference next state from the mode rules using plain arithmetic.
    function automatic logic [3:0] model_next(input logic [3:0] q, input logic en,
                                              input logic [1:0] mode, input logic [3:0] j,
                                              input logic [3:0] k, input logic [3:0] d);
        logic [3:0] r;
        int         v;
        r = q;
        v = int'(q);
        if (!en) return q;
        case (mode)
            2'b00: begin
                for (int i = 0; i < 4; i++) begin
                    if (j[i] && k[i])       r[i] = ~q[i];
                    else if (j[i] && !k[i]) r[i] = 1'b1;
                    else if (!j[i] && k[i]) r[i] = 1'b0;
                end
                return r;
            end
            2'b01:   return (v >= MAXC) ? 4'd0 : 4'(v + 1);
            2'b10:   return (v == 0) ? 4'(MAXC) : 4'(v - 1);
            default: return d;
        endcase
    endfunction

    function automatic logic model_tc(input logic [3:0] q, input logic en, input logic [1:0] mode);
        return en && ((mode == 2'b01 && int'(q) == MAXC) || (mode == 2'b10 && q == 4'd0));
    endfunction

    // Drive one set of inputs and let combinational outputs settle.
    task automatic apply(input logic en, input logic [1:0] mode, input logic [3:0] j,
                         input logic [3:0] k, input logic [3:0] d);
        EN   = en;
        MODE = mode;
        J    = j;
        K    = k;
        D    = d;
        #1;
    endtask

    // Advance the model with the driven inputs and take one rising edge.
    task automatic tick();
        exp_q = model_next(exp_q, EN, MODE, J, K, D);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        apply(1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
        #12;
        checks++;
        if (Q !== RSTV) begin
            errors++;
            $display("[TB] FAIL reset_q: got %b expected %b", Q, RSTV);
        end
        checks++;
        if (Qbar !== ~RSTV) begin
            errors++;
            $display("[TB] FAIL reset_qbar: got %b expected %b", Qbar, ~RSTV);
        end
        checks++;
        if (TC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tc: got %b expected 0", TC);
        end
        @(negedge CLK);
        RST   = 1'b0;
        exp_q = RSTV;
    endtask

    task automatic test_jk();
        logic [3:0] jv[4]  = '{4'b0000, 4'b1010, 4'b0000, 4'b1111};
        logic [3:0] kv[4]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
        logic [3:0] qv[4]  = '{4'b0000, 4'b1010, 4'b1010, 4'b0101};
        for (int s = 0; s < 4; s++) begin
            apply(1'b1, 2'b00, jv[s], kv[s], 4'hF);
            checks++;
            if (TC !== 1'b0) begin
                errors++;
                $display("[TB] FAIL jk_tc step%0d: got %b expected 0", s, TC);
            end
            tick();
            checks++;
            if (Q !== qv[s] || Q !== exp_q) begin
                errors++;
                $display("[TB] FAIL jk_q step%0d: got %b expected %b", s, Q, qv[s]);
            end
            checks++;
            if (Qbar !== ~qv[s]) begin
                errors++;
                $display("[TB] FAIL jk_qbar step%0d: got %b expected %b", s, Qbar, ~qv[s]);
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] seq[12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        apply(1'b1, 2'b11, 4'h0, 4'h0, 4'd0);
        tick();
        for (int s = 0; s < 12; s++) begin
            apply(1'b1, 2'b01, 4'hF, 4'hF, 4'h0);
            checks++;
            if (TC !== (exp_q == 4'd9)) begin
                errors++;
                $display("[TB] FAIL up_tc step%0d: got %b expected %b (Q=%0d)", s, TC, exp_q == 4'd9, Q);
            end
            tick();
            checks++;
            if (Q !== seq[s] || Q !== exp_q) begin
                errors++;
                $display("[TB] FAIL up_q step%0d: got %0d expected %0d", s, Q, seq[s]);
            end
        end
    endtask

    task automatic test_down();
        logic [3:0] seq[3] = '{4'd0, 4'd9, 4'd8};
        apply(1'b1, 2'b11, 4'h0, 4'h0, 4'd1);
        tick();
        for (int s = 0; s < 3; s++) begin
            apply(1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
            checks++;
            if (TC !== (exp_q == 4'd0)) begin
                errors++;
                $display("[TB] FAIL down_tc step%0d: got %b expected %b", s, TC, exp_q == 4'd0);
            end
            tick();
            checks++;
            if (Q !== seq[s]) begin
                errors++;
                $display("[TB] FAIL down_q step%0d: got %0d expected %0d", s, Q, seq[s]);
            end
        end
    endtask

    task automatic test_out_of_range();
        apply(1'b1, 2'b11, 4'h0, 4'h0, 4'b1100);
        tick();
        checks++;
        if (Q !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL oor_load: got %b expected 1100", Q);
        end
        apply(1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
        checks++;
        if (TC !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oor_up_tc: got %b expected 0", TC);
        end
        tick();
        checks++;
        if (Q !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL oor_up_q: got %b expected 0000", Q);
        end
        apply(1'b1, 2'b11, 4'h0, 4'h0, 4'b1100);
        tick();
        apply(1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
        tick();
        checks++;
        if (Q !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL oor_down_q: got %b expected 1011", Q);
        end
    endtask

    task automatic test_hold();
        logic [1:0] modes[3] = '{2'b01, 2'b10, 2'b00};
        apply(1'b1, 2'b11, 4'h0, 4'h0, 4'd5);
        tick();
        for (int s = 0; s < 3; s++) begin
            apply(1'b0, modes[s], 4'hF, 4'hF, 4'hA);
            checks++;
            if (TC !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_tc step%0d: got %b expected 0", s, TC);
            end
            tick();
            checks++;
            if (Q !== 4'd5) begin
                errors++;
                $display("[TB] FAIL hold_q step%0d: got %0d expected 5", s, Q);
            end
        end
        apply(1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
        tick();
        checks++;
        if (Q !== 4'd6) begin
            errors++;
            $display("[TB] FAIL hold_resume: got %0d expected 6", Q);
        end
    endtask

    task automatic test_async_reset();
        apply(1'b1, 2'b11, 4'h0, 4'h0, 4'd7);
        tick();
        apply(1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
        RST = 1'b1;
        #1;
        checks++;
        if (Q !== RSTV || Qbar !== ~RSTV) begin
            errors++;
            $display("[TB] FAIL async_rst: got Q=%b Qbar=%b expected Q=%b", Q, Qbar, RSTV);
        end
        @(negedge CLK);
        RST   = 1'b0;
        exp_q = RSTV;
        tick();
        checks++;
        if (Q !== RSTV + 4'd1) begin
            errors++;
            $display("[TB] FAIL async_resume: got %0d expected %0d", Q, RSTV + 4'd1);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 300; s++) begin
            apply($urandom_range(7, 0) != 0, 2'($urandom_range(3, 0)),
                  4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
            if ($urandom_range(49, 0) == 0) begin
                RST = 1'b1;
                #1;
                exp_q = RSTV;
                checks++;
                if (Q !== RSTV) begin
                    errors++;
                    $display("[TB] FAIL rand_rst step%0d: got %b expected %b", s, Q, RSTV);
                end
                @(negedge CLK);
                RST = 1'b0;
                #1;
            end
            checks++;
            if (TC !== model_tc(exp_q, EN, MODE)) begin
                errors++;
                $display("[TB] FAIL rand_tc step%0d: got %b expected %b (Q=%b mode=%b en=%b)",
                         s, TC, model_tc(exp_q, EN, MODE), Q, MODE, EN);
            end
            tick();
            checks++;
            if (Q !== exp_q || Qbar !== ~exp_q) begin
                errors++;
                $display("[TB] FAIL rand_q step%0d: got Q=%b Qbar=%b expected Q=%b", s, Q, Qbar, exp_q);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_q  = RSTV;
        test_reset();
        test_jk();
        test_up_wrap();
        test_down();
        test_out_of_range();
        test_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
